// File: rtl/dbg_wb_arbiter.sv
// Two-master classic Wishbone arbiter sharing the system bus between the core (m0)
// and the debug master (m1), with a stall timeout so a hung slave cannot wedge debug.
module dbg_wb_arbiter #(
  parameter int unsigned TIMEOUT  = 256,
  parameter bit          DBG_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rstn_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,

  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam bit          TO_EN  = (TIMEOUT != 0);
  localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic        last_m1;
  logic [15:0] stall_cnt, stall_cnt_nxt, cnt_inc;
  logic        granted_stb, stall, hit;

  // cnt_inc is the stall count including the current cycle, so the error lands on stall cycle TIMEOUT
  assign cnt_inc = stall_cnt + 16'd1;

  always_comb begin
    granted_stb = 1'b0;
    case (state)
      GNT0:    granted_stb = m0_stb_i;
      GNT1:    granted_stb = m1_stb_i;
      default: granted_stb = 1'b0;
    endcase
    stall = granted_stb && !s_ack_i && !s_err_i;
    hit   = TO_EN && stall && (cnt_inc == TO_VAL);
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      last_m1   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
      if (state_nxt != state) begin
        if (state_nxt == GNT0) last_m1 <= 1'b0;
        else if (state_nxt == GNT1) last_m1 <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = (DBG_PRIO || !last_m1) ? GNT1 : GNT0;
        else if (m1_cyc_i)        state_nxt = GNT1;
        else if (m0_cyc_i)        state_nxt = GNT0;
      end
      GNT0:    if (!m0_cyc_i) state_nxt = m1_cyc_i ? GNT1 : IDLE;
      GNT1:    if (!m1_cyc_i) state_nxt = m0_cyc_i ? GNT0 : IDLE;
      default: state_nxt = IDLE;
    endcase

    stall_cnt_nxt = cnt_inc;
    if (state == IDLE || state_nxt != state || !stall || hit) stall_cnt_nxt = '0;
  end

  // Only the granted master's signals reach the outputs; the other side is held at zero
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = 2'b00;
    case (state)
      GNT0: begin
        gnt_o    = 2'b01;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i && !hit;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i || hit;
      end
      GNT1: begin
        gnt_o    = 2'b10;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i && !hit;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i || hit;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dbg_wb_arbiter.sv
// Bench for dbg_wb_arbiter: a fixed-priority and a round-robin instance share stimulus
// and are checked every cycle against a grant-ownership model of the arbiter.
module tb_dbg_wb_arbiter;

  localparam int TO = 8;

  logic        clk;
  logic        rstn_i;
  logic [1:0]  cyc, stb, we;
  logic [3:0]  sel  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [31:0] s_dat;
  logic        s_ack, s_err;

  logic [1:0]  p_gnt, r_gnt;
  logic        p_s_cyc, p_s_stb, p_s_we, r_s_cyc, r_s_stb, r_s_we;
  logic [3:0]  p_s_sel, r_s_sel;
  logic [31:0] p_s_adr, p_s_dat, r_s_adr, r_s_dat;
  logic        p_m0_ack, p_m0_err, p_m1_ack, p_m1_err;
  logic        r_m0_ack, r_m0_err, r_m1_ack, r_m1_err;
  logic [31:0] p_m0_dat, p_m1_dat, r_m0_dat, r_m1_dat;

  int total = 0;
  int bad   = 0;

  // model: owner -1 = nobody, 0 = core, 1 = debug; stall = completed stalled cycles
  int owner [2];
  int last  [2];
  int stall [2];

  logic [1:0]  rc;
  logic [31:0] rd;
  int          rr;

  dbg_wb_arbiter #(.TIMEOUT(TO), .DBG_PRIO(1'b1)) dut_prio (
    .clk(clk), .rstn_i(rstn_i),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(p_m0_dat), .m0_ack_o(p_m0_ack), .m0_err_o(p_m0_err),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(p_m1_dat), .m1_ack_o(p_m1_ack), .m1_err_o(p_m1_err),
    .s_cyc_o(p_s_cyc), .s_stb_o(p_s_stb), .s_we_o(p_s_we), .s_sel_o(p_s_sel),
    .s_adr_o(p_s_adr), .s_dat_o(p_s_dat), .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(p_gnt)
  );

  dbg_wb_arbiter #(.TIMEOUT(TO), .DBG_PRIO(1'b0)) dut_rr (
    .clk(clk), .rstn_i(rstn_i),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(r_m0_dat), .m0_ack_o(r_m0_ack), .m0_err_o(r_m0_err),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(r_m1_dat), .m1_ack_o(r_m1_ack), .m1_err_o(r_m1_err),
    .s_cyc_o(r_s_cyc), .s_stb_o(r_s_stb), .s_we_o(r_s_we), .s_sel_o(r_s_sel),
    .s_adr_o(r_s_adr), .s_dat_o(r_s_dat), .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(r_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit timeoutHit(input int k);
    int o;
    o = owner[k];
    if (o < 0) return 1'b0;
    return stb[o] && !s_ack && !s_err && (stall[k] + 1 == TO);
  endfunction

  task automatic resetModels();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1;
      last[k]  = 0;
      stall[k] = 0;
    end
  endtask

  // instance 0 has fixed debug priority, instance 1 alternates on ties
  task automatic advanceModel(input int k);
    int  o, nxt;
    bit  h;
    if (!rstn_i) begin
      owner[k] = -1; last[k] = 0; stall[k] = 0;
      return;
    end
    o = owner[k];
    h = timeoutHit(k);
    if (o < 0) begin
      if (cyc[0] && cyc[1]) nxt = (k == 0) ? 1 : ((last[k] == 1) ? 0 : 1);
      else if (cyc[1])      nxt = 1;
      else if (cyc[0])      nxt = 0;
      else                  nxt = -1;
    end else if (cyc[o])    nxt = o;
    else if (cyc[1-o])      nxt = 1 - o;
    else                    nxt = -1;
    if (o >= 0 && nxt == o && stb[o] && !s_ack && !s_err && !h) stall[k] = stall[k] + 1;
    else stall[k] = 0;
    if (nxt >= 0 && nxt != o) last[k] = nxt;
    owner[k] = nxt;
  endtask

  task automatic checkInst(input int k, input logic [1:0] gnt, input logic scyc, input logic sstb,
                           input logic swe, input logic [3:0] ssel, input logic [31:0] sadr,
                           input logic [31:0] sdat, input logic a0, input logic e0, input logic [31:0] d0,
                           input logic a1, input logic e1, input logic [31:0] d1);
    int          o;
    bit          h;
    logic [1:0]  e_gnt;
    logic        e_scyc, e_sstb, e_swe;
    logic [3:0]  e_ssel;
    logic [31:0] e_sadr, e_sdat;
    logic        e_ack [2];
    logic        e_err [2];
    logic [31:0] e_dat [2];
    o = owner[k];
    h = timeoutHit(k);
    e_gnt = 2'b00; e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0; e_ssel = '0; e_sadr = '0; e_sdat = '0;
    for (int i = 0; i < 2; i++) begin
      e_ack[i] = 1'b0; e_err[i] = 1'b0; e_dat[i] = '0;
    end
    if (o >= 0) begin
      e_gnt    = (o == 0) ? 2'b01 : 2'b10;
      e_scyc   = cyc[o];
      e_sstb   = stb[o] && !h;
      e_swe    = we[o];
      e_ssel   = sel[o];
      e_sadr   = adr[o];
      e_sdat   = wdat[o];
      e_ack[o] = s_ack;
      e_err[o] = s_err || h;
      e_dat[o] = s_dat;
    end
    checkOutput($sformatf("i%0d_gnt", k),    32'(gnt),  32'(e_gnt));
    checkOutput($sformatf("i%0d_s_cyc", k),  32'(scyc), 32'(e_scyc));
    checkOutput($sformatf("i%0d_s_stb", k),  32'(sstb), 32'(e_sstb));
    checkOutput($sformatf("i%0d_s_we", k),   32'(swe),  32'(e_swe));
    checkOutput($sformatf("i%0d_s_sel", k),  32'(ssel), 32'(e_ssel));
    checkOutput($sformatf("i%0d_s_adr", k),  sadr, e_sadr);
    checkOutput($sformatf("i%0d_s_dat", k),  sdat, e_sdat);
    checkOutput($sformatf("i%0d_m0_ack", k), 32'(a0), 32'(e_ack[0]));
    checkOutput($sformatf("i%0d_m0_err", k), 32'(e0), 32'(e_err[0]));
    checkOutput($sformatf("i%0d_m0_dat", k), d0, e_dat[0]);
    checkOutput($sformatf("i%0d_m1_ack", k), 32'(a1), 32'(e_ack[1]));
    checkOutput($sformatf("i%0d_m1_err", k), 32'(e1), 32'(e_err[1]));
    checkOutput($sformatf("i%0d_m1_dat", k), d1, e_dat[1]);
  endtask

  task automatic checkBoth();
    checkInst(0, p_gnt, p_s_cyc, p_s_stb, p_s_we, p_s_sel, p_s_adr, p_s_dat,
              p_m0_ack, p_m0_err, p_m0_dat, p_m1_ack, p_m1_err, p_m1_dat);
    checkInst(1, r_gnt, r_s_cyc, r_s_stb, r_s_we, r_s_sel, r_s_adr, r_s_dat,
              r_m0_ack, r_m0_err, r_m0_dat, r_m1_ack, r_m1_err, r_m1_dat);
  endtask

  // one clock: the model takes the edge with the old inputs, then new inputs are applied and checked
  task automatic applyStimulus(input logic [1:0] c, input logic [1:0] s, input logic [1:0] w,
                               input logic ack, input logic err, input logic [31:0] rdat);
    @(posedge clk);
    #1;
    advanceModel(0);
    advanceModel(1);
    cyc = c; stb = s; we = w;
    s_ack = ack; s_err = err; s_dat = rdat;
    #3;
    checkBoth();
  endtask

  initial begin
    rstn_i = 1'b0;
    cyc = '0; stb = '0; we = '0; s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
    for (int i = 0; i < 2; i++) begin
      sel[i] = 4'hf; adr[i] = '0; wdat[i] = '0;
    end
    resetModels();

    $display("[TB] reset");
    applyStimulus(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 32'hAAAA5555);
    checkOutput("reset_gnt", 32'(p_gnt), 32'd0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    rstn_i = 1'b1;

    $display("[TB] core single read");
    adr[0] = 32'h0000_0100; sel[0] = 4'hf;
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_gnt_idle", 32'(p_gnt), 32'd0);
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_gnt", 32'(p_gnt), 32'b01);
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 32'hDEADBEEF);
    checkOutput("t1_dat", p_m0_dat, 32'hDEADBEEF);
    checkOutput("t1_ack", 32'(p_m0_ack), 32'd1);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_gnt_end", 32'(p_gnt), 32'd0);

    $display("[TB] simultaneous request and handoff");
    wdat[0] = 32'h1234_5678; adr[0] = 32'h0000_0200;
    wdat[1] = 32'h0BAD_F00D; adr[1] = 32'h0000_0300;
    applyStimulus(2'b11, 2'b11, 2'b01, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'b11, 2'b11, 2'b01, 1'b1, 1'b0, 32'h0);
    checkOutput("t2_gnt_dbg", 32'(p_gnt), 32'b10);
    applyStimulus(2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 32'h0);
    checkOutput("t2_gnt_core", 32'(p_gnt), 32'b01);
    checkOutput("t2_sdat", p_s_dat, 32'h1234_5678);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);

    $display("[TB] back-to-back alternation");
    applyStimulus(2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 32'h0);
    for (int g = 0; g < 6; g++) begin
      applyStimulus(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 32'(g));
      checkOutput($sformatf("t3_gnt%0d", g), 32'(r_gnt), (g % 2 == 0) ? 32'b10 : 32'b01);
      applyStimulus((g % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);

    $display("[TB] timeout");
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= TO; i++) begin
      applyStimulus(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("t4_err%0d", i), 32'(p_m1_err), (i == TO) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t4_stb%0d", i), 32'(p_s_stb), (i == TO) ? 32'd0 : 32'd1);
    end
    applyStimulus(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("t4_hold", 32'(p_gnt), 32'b10);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);

    $display("[TB] core burst blocks debug");
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0);
    for (int b = 0; b < 4; b++) begin
      adr[0] = 32'h0000_1000 + 32'(b * 4);
      applyStimulus(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 32'hB0000000 + 32'(b));
      checkOutput($sformatf("t5_dat%0d", b), p_m0_dat, 32'hB0000000 + 32'(b));
      checkOutput($sformatf("t5_m1ack%0d", b), 32'(p_m1_ack), 32'd0);
    end
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("t5_gnt_dbg", 32'(p_gnt), 32'b10);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);

    $display("[TB] reset mid-transfer");
    applyStimulus(2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_gnt_pre", 32'(p_gnt), 32'b10);
    #3;
    rstn_i = 1'b0;
    #1;
    resetModels();
    checkOutput("t6_gnt_rst", 32'(p_gnt), 32'd0);
    checkOutput("t6_scyc_rst", 32'(p_s_cyc), 32'd0);
    checkBoth();
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("t6_ack_rst", 32'(p_m1_ack), 32'd0);
    rstn_i = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_gnt_req", 32'(p_gnt), 32'd0);
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_gnt_new", 32'(p_gnt), 32'b10);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0);

    $display("[TB] random traffic");
    rc = 2'b00;
    for (int n = 0; n < 1200; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(3) == 0) rc[i] = ~rc[i];
        sel[i]  = 4'($urandom);
        adr[i]  = $urandom;
        wdat[i] = $urandom;
      end
      rd = $urandom;
      rr = int'($urandom_range(19));
      if (n < 700)
        applyStimulus(rc, rc & 2'($urandom), 2'($urandom), rr < 6, rr == 19, rd);
      else
        applyStimulus(rc, rc | 2'($urandom_range(1)), 2'($urandom), rr == 0, 1'b0, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_wb_arbiter.md
Name: dbg_wb_arbiter

Overview:
- Two-master Wishbone (classic, 32-bit) arbiter that shares the single system bus between the core data master (m0) and the debug module master (m1, driven by the debug UART TAP path).
- Debug accesses must reach memory and peripherals while the core is running or halted, without corrupting in-flight core transactions.
- A bus timeout guarantees that a hung slave can never deadlock the debug link.
- Sits between both masters and the system interconnect.

Parameters:
- TIMEOUT, 256, consecutive stalled cycles before error termination; 0 disables the timeout; legal range 0..65535.
- DBG_PRIO, 1, arbitration policy: 1 = m1 (debug) has fixed priority; 0 = round-robin between m0 and m1.

Ports:
- clk  in  1  clock.
- rstn_i  in  1  asynchronous reset, active-low.
- mX_cyc_i  in  1  master X bus cycle (X = 0 core, 1 debug).
- mX_stb_i  in  1  master X strobe.
- mX_we_i  in  1  master X write enable.
- mX_sel_i  in  4  master X byte select.
- mX_adr_i  in  32  master X address.
- mX_dat_i  in  32  master X write data.
- mX_dat_o  out  32  read data to master X.
- mX_ack_o  out  1  acknowledge to master X.
- mX_err_o  out  1  error to master X.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave bus.
- s_sel_o  out  4  to slave bus.
- s_adr_o  out  32  to slave bus.
- s_dat_o  out  32  to slave bus.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge.
- s_err_i  in  1  slave error.
- gnt_o  out  2  one-hot current grant; 00 = none (debug visibility).

Behaviour:
- Grant state machine, registered:
  - States: IDLE, GNT0, GNT1. Reset state IDLE; gnt_o = 00.
  - Outputs are zero in reset/IDLE: all s_* outputs 0, all mX_ack_o/mX_err_o 0, all mX_dat_o 0.
- IDLE transitions:
  - If m1_cyc_i and m0_cyc_i are both 1: DBG_PRIO=1 -> GNT1. DBG_PRIO=0 -> grant the master not granted most recently; the last-grant flag resets to m0, so m1 wins the first tie.
  - Otherwise go to the GNT state of whichever cyc is 1; stay in IDLE if neither.
  - Grant latency: 1 cycle from cyc rising to s_cyc_o.
- GNTx behaviour:
  - s_cyc/stb/we/sel/adr/dat are combinationally muxed from master x.
  - mx_ack_o = s_ack_i, mx_err_o = s_err_i, mx_dat_o = s_dat_i.
  - The non-granted master sees ack = 0, err = 0, dat = 0 and simply waits.
- Grant hold: the grant is held while mx_cyc_i = 1, covering multi-beat cycles. There is no preemption, including for debug.
- Release, on the cycle mx_cyc_i = 0:
  - If the other master's cyc is 1, the next state is its GNT state (direct handoff, no IDLE bubble).
  - Otherwise the next state is IDLE.
  - s_cyc_o follows mx_cyc_i combinationally, so it drops the same cycle.
  - The round-robin last-grant flag updates on every grant entry.
- Timeout counter (16 bit):
  - Clears on: IDLE, s_ack_i, s_err_i, granted stb = 0, and any grant change.
  - Increments each granted cycle with stb = 1 and no slave ack/err.
  - When the counter equals TIMEOUT (TIMEOUT > 0), on that cycle: mx_err_o = 1 for exactly 1 cycle, s_stb_o is forced 0, and the counter clears.
  - The grant remains until the master drops cyc.
- A slave ack/err arriving on the same cycle as the timeout takes precedence: it is passed through and no timeout err is generated.
- Simultaneous events:
  - Both cyc drop in the same cycle -> IDLE.
  - A new request and a release in the same cycle follow the handoff rule above.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. The aborted master receives no ack.
- No combinational path from mX_cyc_i of the non-granted master to any output.

Test Plan:
1. m0 single read to 0x0000_0100, slave acks after 2 cycles with 0xDEADBEEF -> m0_dat_o = 0xDEADBEEF with m0_ack_o high 1 cycle; gnt_o sequence 00 -> 01 -> 00; m1 outputs stay 0.
2. m0_cyc_i and m1_cyc_i rise in the same cycle, DBG_PRIO=1 -> gnt_o = 10. After m1 drops cyc, gnt_o = 01 on the next cycle with no 00 cycle; the m0 write of 0x1234_5678 reaches s_dat_o.
3. DBG_PRIO=0, both masters hold continuous back-to-back requests for 6 grants -> gnt_o alternates 10, 01, 10, 01, 10, 01.
4. TIMEOUT=8, m1 strobe held with the slave never acking -> m1_err_o high exactly on stall cycle 8, s_stb_o = 0 on that cycle; gnt_o stays 10 until m1_cyc_i falls.
5. m0 holds cyc across a 4-beat burst while m1 requests -> m1 is not granted until m0_cyc_i falls; the 4 beats are acked in order; no m1_ack_o pulses during the burst.
6. rstn_i asserted mid-transfer during GNT1 -> gnt_o = 00 and s_cyc_o = 0 asynchronously. After release, a fresh m1 request is granted 1 cycle after its cyc rises.
